// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
// Contents: FSM state enum, PRBS7 seed/taps, PRBS7 next-state helper.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LIGHT_UP = 3'd1,
    HOLD     = 3'd2,
    GO       = 3'd3,
    DONE     = 3'd4
  } f1_state_e;

  localparam int unsigned PRBS_W     = 7;
  localparam logic [6:0]  PRBS_SEED  = 7'h01;
  localparam int unsigned PRBS_TAP_A = 6;
  localparam int unsigned PRBS_TAP_B = 2;

  // Maximal-length x^7 + x^3 + 1 step; period 127, never reaches zero from a non-zero seed.
  function automatic logic [6:0] prbs7_next(input logic [6:0] q);
    return {q[5:0], q[PRBS_TAP_A] ^ q[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/prbs7_gen.sv
// 7-bit maximal-length PRBS generator, reusable random-delay source.
// Ports: clk, rst_n (async active-low), en (advance enable), q (current PRBS value).
module prbs7_gen
  import f1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [6:0] q
);

  // PRBS state register; reset seeds a non-zero value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= PRBS_SEED;
    end else if (en) begin
      q <= prbs7_next(q);
    end
  end

endmodule

// File: rtl/f1_light_sequencer.sv
// F1 start-light controller: lights lamps one per tick, holds for a random
// (or fixed, with F1_FIXED_DELAY_EN) number of ticks, then measures reaction
// time in clk cycles until stop, flagging false starts.
// Ports: clk, rst_n (async active-low), trigger, tick, stop (inputs);
//        lights, busy, rt_valid, rt_count, false_start (registered outputs).
// Build option: define F1_FIXED_DELAY_EN to hold for FIXED_DELAY ticks.
module f1_light_sequencer
  import f1_pkg::*;
#(
  parameter int unsigned N_LIGHTS    = 8,
  parameter int unsigned DELAY_W     = 7,
  parameter int unsigned RT_W        = 16,
  parameter int unsigned FIXED_DELAY = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trigger,
  input  logic                tick,
  input  logic                stop,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic                rt_valid,
  output logic [RT_W-1:0]     rt_count,
  output logic                false_start
);

`ifdef F1_FIXED_DELAY_EN
  localparam bit USE_FIXED = 1'b1;
`else
  localparam bit USE_FIXED = 1'b0;
`endif

  f1_state_e             state, state_nxt;
  logic [N_LIGHTS-1:0]   lights_nxt;
  logic                  busy_nxt;
  logic                  rt_valid_nxt;
  logic [RT_W-1:0]       rt_count_nxt;
  logic                  false_start_nxt;
  logic [DELAY_W-1:0]    dly_cnt, dly_cnt_nxt;
  logic [RT_W-1:0]       rt_cnt, rt_cnt_nxt;
  logic [PRBS_W-1:0]     prbs_q;
  logic [DELAY_W-1:0]    delay_src;

  // Free-running random source; advancing every clk lets human timing pick the delay.
  prbs7_gen u_prbs (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .q     (prbs_q)
  );

  assign delay_src = USE_FIXED ? DELAY_W'(FIXED_DELAY) : DELAY_W'(prbs_q);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lights      <= '0;
      busy        <= 1'b0;
      rt_valid    <= 1'b0;
      rt_count    <= '0;
      false_start <= 1'b0;
      dly_cnt     <= '0;
      rt_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      lights      <= lights_nxt;
      busy        <= busy_nxt;
      rt_valid    <= rt_valid_nxt;
      rt_count    <= rt_count_nxt;
      false_start <= false_start_nxt;
      dly_cnt     <= dly_cnt_nxt;
      rt_cnt      <= rt_cnt_nxt;
    end
  end

  // Next-state and output logic; stop outranks tick in LIGHT_UP/HOLD.
  always_comb begin
    state_nxt       = state;
    lights_nxt      = lights;
    rt_valid_nxt    = 1'b0;
    rt_count_nxt    = rt_count;
    false_start_nxt = false_start;
    dly_cnt_nxt     = dly_cnt;
    rt_cnt_nxt      = rt_cnt;

    case (state)
      IDLE: begin
        if (trigger) begin
          lights_nxt      = '0;
          false_start_nxt = 1'b0;
          state_nxt       = LIGHT_UP;
        end
      end
      LIGHT_UP: begin
        if (stop) begin
          lights_nxt      = '0;
          false_start_nxt = 1'b1;
          state_nxt       = IDLE;
        end else if (tick) begin
          lights_nxt = {lights[N_LIGHTS-2:0], 1'b1};
          // This tick lights the last lamp.
          if (&lights[N_LIGHTS-2:0]) begin
            dly_cnt_nxt = delay_src;
            state_nxt   = HOLD;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          lights_nxt      = '0;
          false_start_nxt = 1'b1;
          state_nxt       = IDLE;
        end else if (tick) begin
          dly_cnt_nxt = dly_cnt - DELAY_W'(1);
          if (dly_cnt == DELAY_W'(1)) begin
            lights_nxt = '0;
            rt_cnt_nxt = '0;
            state_nxt  = GO;
          end
        end
      end
      GO: begin
        if (stop) begin
          rt_count_nxt = rt_cnt;
          rt_valid_nxt = 1'b1;
          state_nxt    = DONE;
        end else if (rt_cnt != {RT_W{1'b1}}) begin
          rt_cnt_nxt = rt_cnt + RT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == LIGHT_UP) || (state_nxt == HOLD) || (state_nxt == GO);
  end

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Directed self-checking bench for f1_light_sequencer.
module tb_f1_light_sequencer;

  localparam int unsigned N_LIGHTS    = 8;
  localparam int unsigned DELAY_W     = 7;
  localparam int unsigned RT_W        = 16;
  localparam int unsigned FIXED_DELAY = 5;

  logic                clk;
  logic                rst_n;
  logic                trigger;
  logic                tick;
  logic                stop;
  logic [N_LIGHTS-1:0] lights;
  logic                busy;
  logic                rt_valid;
  logic [RT_W-1:0]     rt_count;
  logic                false_start;

  int checks = 0;
  int errors = 0;
  logic [6:0] m;
  int d_exp;

  f1_light_sequencer #(
    .N_LIGHTS    (N_LIGHTS),
    .DELAY_W     (DELAY_W),
    .RT_W        (RT_W),
    .FIXED_DELAY (FIXED_DELAY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger     (trigger),
    .tick        (tick),
    .stop        (stop),
    .lights      (lights),
    .busy        (busy),
    .rt_valid    (rt_valid),
    .rt_count    (rt_count),
    .false_start (false_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PRBS: x^7 + x^3 + 1 from seed 01, one step per clk since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 7'h01;
    else        m <= {m[5:0], m[6] ^ m[2]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick pulse followed by three idle clks (tick every 4 clks).
  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_trigger();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("trig_busy", 32'(busy), 32'd1);
    chk("trig_lights", 32'(lights), 32'd0);
  endtask

  // Light all lamps, capturing the delay the DUT loads on the last tick.
  task automatic light_up();
    for (int i = 0; i < int'(N_LIGHTS); i++) begin
      if (i == int'(N_LIGHTS) - 1) begin
`ifdef F1_FIXED_DELAY_EN
        d_exp = int'(FIXED_DELAY);
`else
        d_exp = int'(m);
`endif
      end
      tick_once();
      chk($sformatf("lights_step%0d", i), 32'(lights), (32'd1 << (i + 1)) - 32'd1);
    end
  endtask

  // Tick through HOLD; returns #1 after the edge where lights went dark.
  task automatic hold_phase();
    int n;
    n = 0;
    while (n < 200) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      n++;
      if (lights == '0) break;
      repeat (3) step();
    end
    chk("hold_len", 32'(n), 32'(d_exp));
    chk("hold_range", 32'((n >= 1) && (n <= 127)), 32'd1);
    chk("go_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    trigger = 1'b0;
    tick    = 1'b0;
    stop    = 1'b0;
    d_exp   = 0;
    #2;
    chk("rst_lights", 32'(lights), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rt_valid", 32'(rt_valid), 32'd0);
    chk("rst_rt_count", 32'(rt_count), 32'd0);
    chk("rst_false_start", 32'(false_start), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Full run: reaction time of 37 clks.
    do_trigger();
    light_up();
    hold_phase();
    repeat (37) step();
    stop = 1'b1;
    step();
    chk("rt_valid_37", 32'(rt_valid), 32'd1);
    chk("rt_count_37", 32'(rt_count), 32'd37);
    // DONE cycle: trigger must be ignored; stop still high.
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("done_trig_busy", 32'(busy), 32'd0);
    chk("rt_valid_pulse", 32'(rt_valid), 32'd0);
    step();
    chk("idle_stop_busy", 32'(busy), 32'd0);
    chk("idle_stop_fs", 32'(false_start), 32'd0);
    stop = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // False start during LIGHT_UP.
    do_trigger();
    repeat (3) tick_once();
    chk("fs_pre_lights", 32'(lights), 32'h07);
    stop = 1'b1;
    step();
    chk("fs_lights", 32'(lights), 32'd0);
    chk("fs_flag", 32'(false_start), 32'd1);
    chk("fs_busy", 32'(busy), 32'd0);
    chk("fs_rt_valid", 32'(rt_valid), 32'd0);
    chk("fs_rt_count", 32'(rt_count), 32'd37);
    step();
    chk("fs_sticky", 32'(false_start), 32'd1);
    stop = 1'b0;
    step();
    do_trigger();
    chk("fs_cleared", 32'(false_start), 32'd0);

    // False start on the same cycle as a HOLD tick.
    light_up();
    tick = 1'b1;
    stop = 1'b1;
    step();
    tick = 1'b0;
    chk("fs_hold_lights", 32'(lights), 32'd0);
    chk("fs_hold_flag", 32'(false_start), 32'd1);
    chk("fs_hold_busy", 32'(busy), 32'd0);
    stop = 1'b0;
    step();
    chk("fs_hold_no_go", 32'(busy), 32'd0);
    chk("fs_hold_no_valid", 32'(rt_valid), 32'd0);
    chk("fs_hold_rt_count", 32'(rt_count), 32'd37);

    // Stop in the first GO cycle gives zero.
    do_trigger();
    light_up();
    hold_phase();
    stop = 1'b1;
    step();
    chk("rt_zero_valid", 32'(rt_valid), 32'd1);
    chk("rt_zero_count", 32'(rt_count), 32'd0);
    stop = 1'b0;
    repeat (2) step();

    // Saturation after 70000 clks in GO.
    do_trigger();
    light_up();
    hold_phase();
    repeat (70000) step();
    stop = 1'b1;
    step();
    chk("rt_sat_valid", 32'(rt_valid), 32'd1);
    chk("rt_sat_count", 32'(rt_count), 32'hFFFF);
    stop = 1'b0;
    repeat (2) step();

    // Asynchronous reset mid-HOLD, then a fresh sequence.
    do_trigger();
    light_up();
    chk("hold_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_lights", 32'(lights), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rt_count", 32'(rt_count), 32'd0);
    chk("arst_fs", 32'(false_start), 32'd0);
    chk("arst_rt_valid", 32'(rt_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    do_trigger();
    light_up();
    hold_phase();
    stop = 1'b1;
    step();
    chk("post_rst_valid", 32'(rt_valid), 32'd1);
    stop = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
